fifo_ctrl: RTL and testbench
============================

Name: fifo_ctrl

Overview:
- Pointer/flag controller placed directly upstream of the Register_File memory; together they form a synchronous FIFO.
- Converts push/pop requests into the memory's wr_en, w_addr and r_addr, and qualifies its registered r_data with rd_valid.
- The memory cannot write and read in the same cycle (a read happens only when wr_en=0), so this block arbitrates simultaneous requests with fair alternation.

Parameters:
- Add, 10, address bits; depth = 2**Add entries; must match the memory's Add.

Ports:
- clk  input  1  rising-edge clock shared with the memory.
- rst_n  input  1  asynchronous active-low reset.
- push  input  1  request to write the memory's w_data (driven by the producer) this cycle.
- pop  input  1  request to read the head entry this cycle.
- push_ack  output  1  push accepted this cycle (combinational).
- pop_ack  output  1  pop accepted this cycle (combinational).
- wr_en  output  1  to memory wr_en; equals push_ack.
- w_addr  output  Add  to memory w_addr; write pointer low bits.
- r_addr  output  Add  to memory r_addr; read pointer low bits.
- rd_valid  output  1  registered; memory r_data holds the popped entry this cycle.
- full  output  1  registered; count == 2**Add.
- empty  output  1  registered; count == 0.
- count  output  Add+1  registered; number of stored entries.

Behaviour:
- Internal state:
  - wr_ptr and rd_ptr, each Add+1 bits (wrap bit plus address).
  - count.
  - prio toggle: 0 means push preferred, 1 means pop preferred.
  - rd_valid flop.
- Async reset (rst_n low): wr_ptr=0, rd_ptr=0, count=0, prio=0, rd_valid=0, full=0, empty=1. Memory contents are not cleared.
- Reset asserted mid-operation clears all state immediately. A read in flight is dropped: rd_valid=0.
- Candidates:
  - can_push = push & ~full.
  - can_pop = pop & ~empty.
- Arbitration (combinational):
  - Only can_push: push_ack=1.
  - Only can_pop: pop_ack=1.
  - Both: grant the side selected by prio. prio then toggles at the clock edge, so a continuous push+pop pattern alternates push, pop, push, pop…
  - prio changes only on a conflict cycle.
  - Ungranted requests are not queued. The requester holds its request until acked.
  - push_ack and pop_ack are never both 1.
- Outputs to memory:
  - w_addr = wr_ptr[Add-1:0].
  - r_addr = rd_ptr[Add-1:0], driven at all times.
  - wr_en = push_ack.
- On push_ack at edge: memory stores the data, wr_ptr+1, count+1.
- On pop_ack at edge: memory (wr_en=0) registers array[r_addr] into r_data, rd_ptr+1, count-1. rd_valid=1 in the following cycle, otherwise 0. Latency pop_ack -> data valid = 1 cycle.
- rd_valid qualifies r_data. r_data also changes on idle cycles (memory reads whenever wr_en=0); consumers ignore it unless rd_valid=1.
- Entry written at edge N can be popped at edge N+1 and reads the new value.
- Pointers wrap modulo 2**(Add+1). The address wraps 2**Add-1 -> 0 with no gap.
- full and empty are derived from the next count value and registered. They never assert together.
- Push when full: push_ack=0, no state change.
- Pop when empty: pop_ack=0, rd_valid stays 0.
- On a full FIFO with push+pop, only the pop can be granted (no conflict), and prio is unchanged. The mirror case holds for empty.

Test Plan (Add=2, depth 4):
- Reset then idle -> empty=1, full=0, count=0, rd_valid=0, w_addr=0, r_addr=0. Assert rst_n=0 mid-sequence -> same values immediately, without waiting for a clock edge.
- Push 8'hFF, 8'hFE, 8'h64, 8'h01 on consecutive cycles, then push 8'hAA -> first four acked, count=4, full=1; fifth push_ack=0 and memory unchanged.
- From full, pop four times -> rd_valid one cycle after each pop_ack, r_data = FF, FE, 64, 01 in order; then empty=1; a fifth pop gives pop_ack=0 and rd_valid=0.
- With two entries stored, hold push=1 and pop=1 for 6 cycles -> acks alternate push, pop, push, pop, push, pop starting with push; count ends at 2; popped data in FIFO order.
- Wrap: push/pop 10 entries (0x10..0x19) with at most 3 resident -> w_addr/r_addr cycle 0,1,2,3,0…; every value is read back in order with no loss.
- Pop one cycle after a push into an empty FIFO (value 8'h5A) -> pop_ack next cycle, rd_valid the cycle after, r_data=8'h5A.

Source files
------------

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer and flag controller for a synchronous FIFO built around
// a single-port-per-cycle register file. The register file can either write
// or read in a given cycle, never both. When push and pop compete, this block
// grants one of them and takes turns between the two sides.
//
// Ports:
//   clk       rising-edge clock shared with the memory
//   rst_n     asynchronous active-low reset
//   push      producer request to write w_data this cycle
//   pop       consumer request to read the head entry this cycle
//   push_ack  push accepted this cycle (combinational)
//   pop_ack   pop accepted this cycle (combinational)
//   wr_en     memory write enable (same as push_ack)
//   w_addr    memory write address (write pointer low bits)
//   r_addr    memory read address (read pointer low bits)
//   rd_valid  memory r_data holds the entry popped on the previous edge
//   full      count == 2**Add (registered)
//   empty     count == 0 (registered)
//   count     number of stored entries (registered)
module fifo_ctrl #(
  parameter int Add = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  logic           pop,
  output logic           push_ack,
  output logic           pop_ack,
  output logic           wr_en,
  output logic [Add-1:0] w_addr,
  output logic [Add-1:0] r_addr,
  output logic           rd_valid,
  output logic           full,
  output logic           empty,
  output logic [Add:0]   count
);

  localparam logic [Add:0] DEPTH = {1'b1, {Add{1'b0}}};
  localparam logic [Add:0] ONE   = {{Add{1'b0}}, 1'b1};

  logic [Add:0] wr_ptr_reg, wr_ptr_next;
  logic [Add:0] rd_ptr_reg, rd_ptr_next;
  logic [Add:0] count_reg, count_next;
  logic         prio_reg, prio_next;
  logic         rd_valid_reg;
  logic         full_reg, full_next;
  logic         empty_reg, empty_next;

  logic can_push, can_pop, conflict;

  // Arbitration. A side that is blocked by a flag never takes part in a
  // conflict, so a full FIFO with push+pop grants the pop without
  // touching prio (and the mirror case for empty).
  always_comb begin
    can_push = push & ~full_reg;
    can_pop  = pop & ~empty_reg;
    conflict = can_push & can_pop;
    push_ack = can_push & ~(conflict & prio_reg);
    pop_ack  = can_pop & ~(conflict & ~prio_reg);
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    prio_next   = prio_reg;
    if (push_ack) begin
      wr_ptr_next = wr_ptr_reg + ONE;
      count_next  = count_reg + ONE;
    end
    if (pop_ack) begin
      rd_ptr_next = rd_ptr_reg + ONE;
      count_next  = count_reg - ONE;
    end
    if (conflict) begin
      prio_next = ~prio_reg;
    end
    // Flags come from the post-edge count so they are glitch-free flops.
    full_next  = (count_next == DEPTH);
    empty_next = (count_next == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      prio_reg     <= 1'b0;
      rd_valid_reg <= 1'b0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      prio_reg     <= prio_next;
      // The memory registers r_data on the same edge as the pop, so the
      // data is valid for exactly the following cycle.
      rd_valid_reg <= pop_ack;
      full_reg     <= full_next;
      empty_reg    <= empty_next;
    end
  end

  assign wr_en    = push_ack;
  assign w_addr   = wr_ptr_reg[Add-1:0];
  assign r_addr   = rd_ptr_reg[Add-1:0];
  assign rd_valid = rd_valid_reg;
  assign full     = full_reg;
  assign empty    = empty_reg;
  assign count    = count_reg;

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: exercises fifo_ctrl (Add=2) together with a behavioural
// register file. A queue-based model is checked against the DUT every cycle;
// directed sequences add literal expectations.
module tb_fifo_ctrl;
  localparam int Add   = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic push = 1'b0;
  logic pop = 1'b0;
  logic push_ack, pop_ack, wr_en, rd_valid, full, empty;
  logic [Add-1:0] w_addr, r_addr;
  logic [Add:0]   count;
  logic [7:0] w_data = 8'h00;
  logic [7:0] r_data;
  logic [7:0] mem [DEPTH];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fifo_ctrl #(.Add(Add)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
    .push_ack(push_ack), .pop_ack(pop_ack), .wr_en(wr_en),
    .w_addr(w_addr), .r_addr(r_addr), .rd_valid(rd_valid),
    .full(full), .empty(empty), .count(count)
  );

  // Register file: writes when wr_en, otherwise registers array[r_addr].
  always @(posedge clk) begin
    if (wr_en) mem[w_addr] <= w_data;
    else       r_data <= mem[r_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  logic [7:0] q[$];
  bit         m_prio;
  bit         m_rdv;
  logic [7:0] m_rdata;
  int         m_wr, m_rd;

  always @(negedge clk) begin
    bit cp, co, ep, eo;
    if (!rst_n) begin
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_count", count, 0);
      chk("rst_rd_valid", rd_valid, 0);
      q.delete();
      m_prio = 0; m_rdv = 0; m_wr = 0; m_rd = 0;
    end else begin
      cp = push && (q.size() < DEPTH);
      co = pop && (q.size() > 0);
      ep = cp && !(co && m_prio);
      eo = co && !(cp && !m_prio);
      chk("m_push_ack", push_ack, ep);
      chk("m_pop_ack", pop_ack, eo);
      chk("m_wr_en", wr_en, ep);
      chk("m_w_addr", w_addr, m_wr % DEPTH);
      chk("m_r_addr", r_addr, m_rd % DEPTH);
      chk("m_count", count, q.size());
      chk("m_full", full, q.size() == DEPTH);
      chk("m_empty", empty, q.size() == 0);
      chk("m_rd_valid", rd_valid, m_rdv);
      if (m_rdv) chk("m_r_data", r_data, m_rdata);
      if (cp && co) m_prio = !m_prio;
      m_rdv = 0;
      if (eo) begin
        m_rdata = q.pop_front();
        m_rdv = 1;
        m_rd++;
      end
      if (ep) begin
        q.push_back(w_data);
        m_wr++;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic       a_push, a_pop, s_rdv;
  logic [7:0] s_rdata;

  // One cycle: drive, sample at the falling edge, return 1 after rising edge.
  task automatic cyc(input bit p, input bit o, input logic [7:0] d);
    push = p; pop = o; w_data = d;
    @(negedge clk);
    a_push = push_ack; a_pop = pop_ack; s_rdv = rd_valid; s_rdata = r_data;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && !empty; k++) cyc(0, 1, 8'h00);
    cyc(0, 0, 8'h00);
    chk("drain_empty", empty, 1);
  endtask

  initial begin
    logic [7:0] fill [4];
    logic [7:0] got [$];
    fill[0] = 8'hFF; fill[1] = 8'hFE; fill[2] = 8'h64; fill[3] = 8'h01;

    // Reset then idle.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_empty", empty, 1);
    chk("reset_full", full, 0);
    chk("reset_count", count, 0);
    chk("reset_w_addr", w_addr, 0);
    chk("reset_r_addr", r_addr, 0);
    rst_n = 1'b1;
    cyc(0, 0, 8'h00);

    // Fill to full, then try one more.
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, fill[i]);
      chk("fill_push_ack", a_push, 1);
    end
    cyc(1, 0, 8'hAA);
    chk("over_push_ack", a_push, 0);
    chk("full_count", count, 4);
    chk("full_flag", full, 1);
    for (int i = 0; i < 4; i++) chk("mem_unchanged", mem[i], fill[i]);

    // Pop four plus one extra on empty.
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 8'h00);
      chk("drain_pop_ack", a_pop, i < 4);
      if (i > 0) begin
        chk("drain_rd_valid", s_rdv, 1);
        chk("drain_r_data", s_rdata, fill[i-1]);
      end
    end
    cyc(0, 0, 8'h00);
    chk("extra_pop_rd_valid", s_rdv, 0);
    chk("drain_empty_flag", empty, 1);

    // Two stored, then continuous push+pop alternates starting with push.
    cyc(1, 0, 8'h30);
    cyc(1, 0, 8'h31);
    for (int i = 0; i < 6; i++) begin
      cyc(1, 1, 8'h40 + 8'(i));
      chk("alt_push_ack", a_push, (i % 2) == 0);
      chk("alt_pop_ack", a_pop, (i % 2) == 1);
    end
    chk("alt_count", count, 2);
    cyc(0, 0, 8'h00);
    chk("alt_last_data", s_rdata, 8'h40);

    // Wrap: ten values through the FIFO with at most three resident.
    drain();
    got.delete();
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 8'h10 + 8'(i));
      if (s_rdv) got.push_back(s_rdata);
      if (i >= 2) begin
        cyc(0, 1, 8'h00);
        if (s_rdv) got.push_back(s_rdata);
      end
    end
    for (int k = 0; k < 6; k++) begin
      cyc(0, !empty, 8'h00);
      if (s_rdv) got.push_back(s_rdata);
    end
    chk("wrap_n", got.size(), 10);
    for (int i = 0; i < 10 && i < got.size(); i++)
      chk("wrap_data", got[i], 8'h10 + 8'(i));

    // Pop one cycle after a push into an empty FIFO.
    cyc(1, 0, 8'h5A);
    cyc(0, 1, 8'h00);
    chk("5a_pop_ack", a_pop, 1);
    cyc(0, 0, 8'h00);
    chk("5a_rd_valid", s_rdv, 1);
    chk("5a_r_data", s_rdata, 8'h5A);

    // Random traffic, checked by the model every cycle.
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));

    // Mid-sequence reset with a read in flight.
    drain();
    cyc(1, 0, 8'h77);
    cyc(1, 0, 8'h78);
    cyc(0, 1, 8'h00);
    push = 0; pop = 0;
    chk("pre_rst_rd_valid", rd_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_empty", empty, 1);
    chk("async_full", full, 0);
    chk("async_count", count, 0);
    chk("async_rd_valid", rd_valid, 0);
    chk("async_w_addr", w_addr, 0);
    chk("async_r_addr", r_addr, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0, 0, 8'h00);

    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
